// File: rtl/ff_bank_pkg.sv
// Shared types for the multimode flip-flop bank: mode encoding and its width.
package ff_bank_pkg;

  localparam int unsigned FF_MODE_COUNT = 4;
  localparam int unsigned FF_MODE_W     = $clog2(FF_MODE_COUNT);

  typedef enum logic [FF_MODE_W-1:0] {
    FF_D  = 2'd0,
    FF_T  = 2'd1,
    FF_JK = 2'd2,
    FF_SR = 2'd3
  } ff_mode_t;

endpackage

// File: rtl/ff_next_state.sv
// Single-bit next-state function for a D/T/JK/SR flip-flop; flags S=R=1 as illegal.
module ff_next_state
  import ff_bank_pkg::*;
(
  input  ff_mode_t mode,
  input  logic     q,
  input  logic     a,
  input  logic     b,
  output logic     nxt,
  output logic     illegal
);

  // Per-mode next-state decode; an illegal SR pair holds the bit
  always_comb begin
    nxt     = q;
    illegal = 1'b0;
    case (mode)
      FF_D:  nxt = a;
      FF_T:  nxt = q ^ a;
      FF_JK: begin
        case ({a, b})
          2'b00:   nxt = q;
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      FF_SR: begin
        case ({a, b})
          2'b00:   nxt = q;
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11: begin
            nxt     = q;
            illegal = 1'b1;
          end
          default: nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
  end

endmodule

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH run-time selectable D/T/JK/SR flip-flops with sync clear,
// per-channel change strobes and an SR illegal-input flag.
module multimode_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [FF_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qn,
  output logic [WIDTH-1:0]     changed,
  output logic                 sr_err
);

  ff_mode_t         mode_s;
  logic [WIDTH-1:0] nxt_s;
  logic [WIDTH-1:0] illegal_s;
  logic [WIDTH-1:0] q_next_s;
  logic             sr_err_next_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] changed_r;
  logic             sr_err_r;

  assign mode_s = ff_mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    ff_next_state u_ns (
      .mode    (mode_s),
      .q       (q_r[i]),
      .a       (a[i]),
      .b       (b[i]),
      .nxt     (nxt_s[i]),
      .illegal (illegal_s[i])
    );
  end

  // Clear beats enable; sr_err only counts cycles that actually evaluate SR
  always_comb begin
    q_next_s      = q_r;
    sr_err_next_s = 1'b0;
    if (clr) begin
      q_next_s      = RESET_VAL;
      sr_err_next_s = 1'b0;
    end else if (en) begin
      q_next_s      = nxt_s;
      sr_err_next_s = (mode_s == FF_SR) && (|illegal_s);
    end else begin
      q_next_s      = q_r;
      sr_err_next_s = 1'b0;
    end
  end

  // State, change strobes and error flag share one edge so they stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r       <= RESET_VAL;
      changed_r <= {WIDTH{1'b0}};
      sr_err_r  <= 1'b0;
    end else begin
      q_r       <= q_next_s;
      changed_r <= q_next_s ^ q_r;
      sr_err_r  <= sr_err_next_s;
    end
  end

  assign q       = q_r;
  assign qn      = ~q_r;
  assign changed = changed_r;
  assign sr_err  = sr_err_r;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Scoreboard bench for multimode_ff_bank: driver pushes model predictions,
// monitor pops and compares one entry per clock edge.
module tb_multimode_ff_bank;

  localparam int unsigned W    = 8;
  localparam logic [W-1:0] RV  = 8'hA5;
  localparam logic [1:0] M_D  = 2'd0;
  localparam logic [1:0] M_T  = 2'd1;
  localparam logic [1:0] M_JK = 2'd2;
  localparam logic [1:0] M_SR = 2'd3;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] changed;
    logic         sr_err;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic [W-1:0] changed;
  logic         sr_err;

  exp_t         exp_q[$];
  logic [W-1:0] model_q;
  int           checks;
  int           errors;

  multimode_ff_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .en      (en),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .q       (q),
    .qn      (qn),
    .changed (changed),
    .sr_err  (sr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".q"}, q, e.q);
    check({tag, ".qn"}, qn, ~e.q);
    check({tag, ".changed"}, changed, e.changed);
    check({tag, ".sr_err"}, {7'd0, sr_err}, {7'd0, e.sr_err});
  endtask

  // Word-level reference built directly from the behavioural rules
  function automatic exp_t predict(input logic [1:0] m, input logic e, input logic c,
                                   input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic [W-1:0] cur);
    exp_t         r;
    logic [W-1:0] n;
    logic [W-1:0] ill;
    logic         err;
    err = 1'b0;
    if (c) n = RV;
    else if (!e) n = cur;
    else begin
      case (m)
        M_D:  n = aa;
        M_T:  n = cur ^ aa;
        M_JK: n = (aa & ~cur) | (~bb & cur);
        default: begin
          ill = aa & bb;
          n   = (((cur | aa) & ~bb) & ~ill) | (cur & ill);
          err = (ill != '0);
        end
      endcase
    end
    r.q       = n;
    r.changed = n ^ cur;
    r.sr_err  = err;
    return r;
  endfunction

  task automatic step(input logic [1:0] m, input logic e, input logic c,
                      input logic [W-1:0] aa, input logic [W-1:0] bb);
    exp_t r;
    mode = m; en = e; clr = c; a = aa; b = bb;
    r = predict(m, e, c, aa, bb, model_q);
    model_q = r.q;
    exp_q.push_back(r);
    @(posedge clk);
    #2;
  endtask

  task automatic hold_reset(input int n);
    exp_t r;
    r.q = RV; r.changed = '0; r.sr_err = 1'b0;
    rst = 1'b1;
    model_q = RV;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(r);
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any edge
  task automatic mid_reset();
    exp_t r;
    r.q = RV; r.changed = '0; r.sr_err = 1'b0;
    rst = 1'b1;
    #1;
    check_all("async_rst", r);
    hold_reset(1);
  endtask

  // Monitor: every edge the DUT presents a result for the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_all("sb", e);
      end
    end
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; clr = 1'b0; en = 1'b0; mode = M_D; a = '0; b = '0;
    model_q = RV;
    hold_reset(2);
    step(M_D, 1'b0, 1'b0, 8'h00, 8'h00);

    // T toggling from zero, then hold with en low
    step(M_D, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) step(M_T, 1'b1, 1'b0, 8'hFF, 8'h00);
    step(M_T, 1'b0, 1'b0, 8'hFF, 8'h00);
    step(M_T, 1'b0, 1'b0, 8'hFF, 8'h00);

    // JK groups: hold, reset, set, toggle; then all toggle
    step(M_D, 1'b1, 1'b0, 8'h0F, 8'h00);
    step(M_JK, 1'b1, 1'b0, 8'hF0, 8'h3C);
    step(M_JK, 1'b1, 1'b0, 8'hFF, 8'hFF);

    // SR with one illegal channel, then a quiet cycle
    step(M_D, 1'b1, 1'b0, 8'h00, 8'h00);
    step(M_SR, 1'b1, 1'b0, 8'h81, 8'h01);
    step(M_SR, 1'b1, 1'b0, 8'h00, 8'h00);
    step(M_SR, 1'b0, 1'b0, 8'hFF, 8'hFF);

    // Clear overrides en/mode
    step(M_D, 1'b1, 1'b0, 8'h3C, 8'h00);
    step(M_D, 1'b1, 1'b1, 8'hFF, 8'h00);
    step(M_SR, 1'b0, 1'b1, 8'hFF, 8'hFF);

    // Mode switch every cycle
    step(M_D, 1'b1, 1'b0, 8'h55, 8'h00);
    step(M_T, 1'b1, 1'b0, 8'hFF, 8'h00);
    step(M_D, 1'b1, 1'b0, 8'h0F, 8'h00);

    // Reset landing during T toggling
    step(M_T, 1'b1, 1'b0, 8'hFF, 8'h00);
    step(M_T, 1'b1, 1'b0, 8'hFF, 8'h00);
    mid_reset();
    step(M_T, 1'b1, 1'b0, 8'hFF, 8'h00);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      logic [1:0] m;
      logic       e;
      logic       c;
      m = 2'($urandom_range(0, 3));
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) mid_reset();
      else step(m, e, c, 8'($urandom), 8'($urandom));
    end

    step(M_D, 1'b0, 1'b0, 8'h00, 8'h00);
    #20;
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
